// File: rtl/cache_model.sv
// Cache system model: a 2-way, 4-set write-back/write-allocate data cache in
// front of a 256-word backing memory, completing every access in one cycle.

module l1dcache (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [5:0]  tag_in,
    input  logic [1:0]  index,
    input  logic [31:0] write_data,
    input  logic [31:0] fill_data,
    output logic        hit,
    output logic [31:0] result,
    output logic        wb_en,
    output logic [7:0]  wb_addr,
    output logic [31:0] wb_data
);

    logic [31:0] cachemem [0:3][0:1];
    logic [5:0]  tags     [0:3][0:1];
    logic        valid    [0:3][0:1];
    logic        dirty    [0:3][0:1];
    logic        lru      [0:3];

    logic hit0;
    logic hit1;
    logic victim_way;
    logic way_sel;

    // Lookup, victim choice and write-back request for the current access.
    always_comb begin
        hit0       = valid[index][0] && (tags[index][0] == tag_in);
        hit1       = valid[index][1] && (tags[index][1] == tag_in);
        hit        = hit0 || hit1;
        victim_way = 1'b0;
        if (!valid[index][0]) begin
            victim_way = 1'b0;
        end else if (!valid[index][1]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru[index];
        end
        way_sel = 1'b0;
        if (hit) begin
            way_sel = hit0 ? 1'b0 : 1'b1;
        end else begin
            way_sel = victim_way;
        end
        wb_en   = !hit && valid[index][victim_way] && dirty[index][victim_way];
        wb_addr = {tags[index][victim_way], index};
        wb_data = cachemem[index][victim_way];
        result  = 32'h0000_0000;
        if (write_en) begin
            result = write_data;
        end else if (hit) begin
            result = cachemem[index][way_sel];
        end else begin
            result = fill_data;
        end
    end

    // Line state update: hit refresh or miss allocation, LRU points at the other way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    cachemem[s][w] <= 32'h0000_0000;
                    tags[s][w]     <= 6'h00;
                    valid[s][w]    <= 1'b0;
                    dirty[s][w]    <= 1'b0;
                end
            end
        end else begin
            lru[index] <= ~way_sel;
            if (hit) begin
                if (write_en) begin
                    cachemem[index][way_sel] <= write_data;
                    dirty[index][way_sel]    <= 1'b1;
                end
            end else begin
                valid[index][way_sel]    <= 1'b1;
                tags[index][way_sel]     <= tag_in;
                dirty[index][way_sel]    <= write_en;
                cachemem[index][way_sel] <= write_en ? write_data : fill_data;
            end
        end
    end

endmodule

module cache_model (
    input  logic        clk,
    input  logic        rst,
    input  logic        report,
    input  logic        write_en,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    logic [31:0] mainmem [0:255];
    logic [31:0] read_data_q;
    logic [31:0] read_data_d;
    logic [15:0] hit_count;
    logic [15:0] hit_count_d;
    logic [15:0] miss_count;
    logic [15:0] miss_count_d;

    logic        hit;
    logic [31:0] result;
    logic        wb_en;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;

    l1dcache l1dcache (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .tag_in     (address[7:2]),
        .index      (address[1:0]),
        .write_data (write_data),
        .fill_data  (mainmem[address]),
        .hit        (hit),
        .result     (result),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    // Next access result and saturating statistics.
    always_comb begin
        read_data_d  = result;
        hit_count_d  = hit_count;
        miss_count_d = miss_count;
        if (hit) begin
            if (hit_count != 16'hFFFF) begin
                hit_count_d = hit_count + 16'h0001;
            end else begin
                hit_count_d = hit_count;
            end
        end else begin
            if (miss_count != 16'hFFFF) begin
                miss_count_d = miss_count + 16'h0001;
            end else begin
                miss_count_d = miss_count;
            end
        end
    end

    // Backing memory, output register and counters; reset discards dirty lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= 32'h0000_0000;
            hit_count   <= 16'h0000;
            miss_count  <= 16'h0000;
            for (int i = 0; i < 256; i++) begin
                mainmem[i] <= 32'h0000_0000;
            end
        end else begin
            read_data_q <= read_data_d;
            hit_count   <= hit_count_d;
            miss_count  <= miss_count_d;
            if (wb_en) begin
                mainmem[wb_addr] <= wb_data;
            end
`ifndef SYNTHESIS
            if (report) begin
                $display("hits=%0d misses=%0d", hit_count, miss_count);
            end
`endif
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_cache_model.sv
// Bench for cache_model: table of accesses with expected read_data and
// cumulative counters, plus reset-discard and counter-saturation sequences.

module tb_cache_model;

    logic        clk;
    logic        rst;
    logic        report;
    logic        write_en;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int tests;
    int fails;

    typedef struct {
        logic        we;
        logic        rep;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_hits;
        logic [15:0] exp_misses;
    } vec_t;

    vec_t        vecs [0:14];
    logic [31:0] exp_q [$];

    cache_model dut (
        .clk        (clk),
        .rst        (rst),
        .report     (report),
        .write_en   (write_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, read_data);
        end else begin
            e = exp_q.pop_front();
            check(name, read_data, e);
        end
    endtask

    task automatic access(input logic we, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string name);
        @(negedge clk);
        write_en   = we;
        address    = a;
        write_data = d;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        report     = 1'b0;
        write_en   = 1'b0;
        address    = 8'h00;
        write_data = 32'h0000_0000;

        vecs[0]  = '{1'b0, 1'b0, 8'h20, 32'h0000_0000, 32'h0000_0000, 16'd0, 16'd1};
        vecs[1]  = '{1'b0, 1'b0, 8'h20, 32'h0000_0000, 32'h0000_0000, 16'd1, 16'd1};
        vecs[2]  = '{1'b1, 1'b1, 8'h20, 32'h00AB_CDEF, 32'h00AB_CDEF, 16'd2, 16'd1};
        vecs[3]  = '{1'b1, 1'b0, 8'h20, 32'h00AB_CDEF, 32'h00AB_CDEF, 16'd3, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 8'h20, 32'h00AB_CDEF, 32'h00AB_CDEF, 16'd4, 16'd1};
        vecs[5]  = '{1'b1, 1'b0, 8'h20, 32'h00AB_CDEF, 32'h00AB_CDEF, 16'd5, 16'd1};
        vecs[6]  = '{1'b1, 1'b0, 8'h20, 32'h00AB_CDEF, 32'h00AB_CDEF, 16'd6, 16'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'h20, 32'h0000_0011, 32'h0000_0011, 16'd7, 16'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'h24, 32'h0000_0022, 32'h0000_0022, 16'd7, 16'd2};
        vecs[9]  = '{1'b0, 1'b0, 8'h28, 32'h0000_0000, 32'h0000_0000, 16'd7, 16'd3};
        vecs[10] = '{1'b0, 1'b0, 8'h20, 32'h0000_0000, 32'h0000_0011, 16'd7, 16'd4};
        vecs[11] = '{1'b0, 1'b0, 8'h24, 32'h0000_0000, 32'h0000_0022, 16'd7, 16'd5};
        vecs[12] = '{1'b1, 1'b0, 8'h07, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 16'd7, 16'd6};
        vecs[13] = '{1'b0, 1'b0, 8'h07, 32'h0000_0000, 32'hA5A5_A5A5, 16'd8, 16'd6};
        vecs[14] = '{1'b0, 1'b0, 8'h20, 32'h0000_0000, 32'h0000_0011, 16'd9, 16'd6};

        repeat (5) @(posedge clk);
        #1;
        check("reset_read_data", read_data, 32'h0000_0000);
        check("reset_hits", {16'h0000, dut.hit_count}, 32'h0000_0000);
        check("reset_misses", {16'h0000, dut.miss_count}, 32'h0000_0000);
        check("reset_valid00", {31'h0, dut.l1dcache.valid[0][0]}, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            report     = vecs[i].rep;
            write_en   = vecs[i].we;
            address    = vecs[i].addr;
            write_data = vecs[i].wdata;
            exp_q.push_back(vecs[i].exp_rd);
            @(posedge clk);
            #1;
            pop_check($sformatf("vec%0d_read_data", i));
            check($sformatf("vec%0d_hits", i), {16'h0000, dut.hit_count}, {16'h0000, vecs[i].exp_hits});
            check($sformatf("vec%0d_misses", i), {16'h0000, dut.miss_count}, {16'h0000, vecs[i].exp_misses});
            if (i == 1) begin
                check("line00_valid", {31'h0, dut.l1dcache.valid[0][0]}, 32'h0000_0001);
                check("line00_tag", {26'h0, dut.l1dcache.tags[0][0]}, 32'h0000_0008);
            end
            if (i == 6) begin
                check("line00_data", dut.l1dcache.cachemem[0][0], 32'h00AB_CDEF);
                check("line00_dirty", {31'h0, dut.l1dcache.dirty[0][0]}, 32'h0000_0001);
                check("mainmem20_not_written", dut.mainmem[8'h20], 32'h0000_0000);
            end
            if (i == 9) begin
                check("wb_mainmem20", dut.mainmem[8'h20], 32'h0000_0011);
            end
            if (i == 10) begin
                check("wb_mainmem24", dut.mainmem[8'h24], 32'h0000_0022);
            end
            @(negedge clk);
            report = 1'b0;
        end

        // Dirty line held across a mid-run reset must be lost.
        access(1'b1, 8'h20, 32'h0000_0055, 32'h0000_0055, "dirty_write_hit");
        check("dirty_before_reset", {31'h0, dut.l1dcache.dirty[0][1]}, 32'h0000_0001);
        @(negedge clk);
        rst        = 1'b1;
        report     = 1'b1;
        write_en   = 1'b1;
        address    = 8'h20;
        write_data = 32'h0000_0099;
        @(posedge clk);
        #1;
        check("midreset_read_data", read_data, 32'h0000_0000);
        check("midreset_hits", {16'h0000, dut.hit_count}, 32'h0000_0000);
        check("midreset_mainmem20", dut.mainmem[8'h20], 32'h0000_0000);
        @(negedge clk);
        rst    = 1'b0;
        report = 1'b0;
        write_en = 1'b0;
        exp_q.push_back(32'h0000_0000);
        @(posedge clk);
        #1;
        pop_check("post_reset_read");
        check("post_reset_misses", {16'h0000, dut.miss_count}, 32'h0000_0001);
        check("post_reset_hits", {16'h0000, dut.hit_count}, 32'h0000_0000);

        // 65536 further hits on the same line: the hit counter must pin at 0xFFFF.
        repeat (65536) @(posedge clk);
        #1;
        check("hit_saturate", {16'h0000, dut.hit_count}, 32'h0000_FFFF);
        check("miss_after_saturate", {16'h0000, dut.miss_count}, 32'h0000_0001);
        check("saturate_read_data", read_data, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
